// File: rtl/can_fault_confinement_if.sv
// Bit-rate signal bundle between the CAN decoder/transmitter and the fault-confinement controller.
// The master side supplies decoder inputs; the slave side is the controller.
interface can_fault_confinement_if;
  logic       SP;
  logic       rx_bit;
  logic       STF_E;
  logic       EOF_E;
  logic       FRM_E;
  logic       CRC_E;
  logic       tx_mode;
  logic       frame_ok;
  logic       ERROR;
  logic       tx_bit;
  logic [1:0] err_state;
  logic [8:0] TEC;
  logic [7:0] REC;

  modport master (
    output SP, rx_bit, STF_E, EOF_E, FRM_E, CRC_E, tx_mode, frame_ok,
    input  ERROR, tx_bit, err_state, TEC, REC
  );

  modport slave (
    input  SP, rx_bit, STF_E, EOF_E, FRM_E, CRC_E, tx_mode, frame_ok,
    output ERROR, tx_bit, err_state, TEC, REC
  );
endinterface

// File: rtl/can_fault_confinement.sv
// Sequences CAN error flag/delimiter onto tx_bit and keeps TEC/REC with active/passive/bus-off confinement.
// Outputs registered one clk after a qualifying SP; no backpressure, state only advances on SP.
module can_fault_confinement #(
  parameter int FLAG_LEN    = 6,
  parameter int DELIM_LEN   = 8,
  parameter int TX_INC      = 8,
  parameter int RX_INC      = 1,
  parameter int PASSIVE_LIM = 128,
  parameter int BUSOFF_LIM  = 256,
  parameter int RECOV_SEQ   = 128,
  parameter int RECOV_BITS  = 11
) (
  input logic                    clk,
  input logic                    reset,
  can_fault_confinement_if.slave bus
);
  localparam int CNT_MAX = (FLAG_LEN > DELIM_LEN)
                         ? ((FLAG_LEN > RECOV_BITS) ? FLAG_LEN : RECOV_BITS)
                         : ((DELIM_LEN > RECOV_BITS) ? DELIM_LEN : RECOV_BITS);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int SEQ_W = $clog2(RECOV_SEQ + 1);

  localparam logic [CNT_W-1:0] FLAG_LAST   = CNT_W'(FLAG_LEN - 1);
  localparam logic [CNT_W-1:0] DELIM_LAST  = CNT_W'(DELIM_LEN - 1);
  localparam logic [CNT_W-1:0] RECOV_LAST  = CNT_W'(RECOV_BITS - 1);
  localparam logic [SEQ_W-1:0] SEQ_LAST    = SEQ_W'(RECOV_SEQ - 1);
  localparam logic [9:0]       TEC_BUSOFF  = 10'(BUSOFF_LIM);
  localparam logic [9:0]       TEC_PASSIVE = 10'(PASSIVE_LIM);
  localparam logic [8:0]       REC_PASSIVE = 9'(PASSIVE_LIM);

  localparam logic [1:0] ST_ACTIVE  = 2'd0;
  localparam logic [1:0] ST_PASSIVE = 2'd1;
  localparam logic [1:0] ST_BUSOFF  = 2'd2;

  typedef enum logic [2:0] {IDLE, FLAG, DELIM_WAIT, DELIM, BUSOFF} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [8:0]       tec_q, tec_d;
  logic [7:0]       rec_q, rec_d;
  logic             error_q, error_d;
  logic             tx_bit_q, tx_bit_d;

  logic       err_det;
  logic [1:0] err_state;
  logic [9:0] tec_sum;
  logic [8:0] rec_sum;
  logic [8:0] tec_inc;
  logic [7:0] rec_inc;
  logic       tec_to_busoff;

  assign err_det = bus.SP & ~(bus.STF_E & bus.EOF_E & bus.FRM_E & bus.CRC_E);

  always_comb begin
    if ({1'b0, tec_q} >= TEC_BUSOFF) begin
      err_state = ST_BUSOFF;
    end else if ({1'b0, tec_q} >= TEC_PASSIVE || {1'b0, rec_q} >= REC_PASSIVE) begin
      err_state = ST_PASSIVE;
    end else begin
      err_state = ST_ACTIVE;
    end
  end

  // Saturating increments: TEC clamps at the bus-off limit, REC at all-ones.
  always_comb begin
    tec_sum       = {1'b0, tec_q} + 10'(TX_INC);
    rec_sum       = {1'b0, rec_q} + 9'(RX_INC);
    tec_to_busoff = bus.tx_mode && (tec_sum >= TEC_BUSOFF);
    tec_inc       = (tec_sum >= TEC_BUSOFF) ? TEC_BUSOFF[8:0] : tec_sum[8:0];
    rec_inc       = rec_sum[8] ? 8'hFF : rec_sum[7:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    seq_d    = seq_q;
    tec_d    = tec_q;
    rec_d    = rec_q;
    error_d  = error_q;
    tx_bit_d = tx_bit_q;
    case (state_q)
      IDLE: begin
        if (err_det) begin
          if (bus.tx_mode) tec_d = tec_inc;
          else             rec_d = rec_inc;
          cnt_d   = '0;
          seq_d   = '0;
          error_d = 1'b0;
          if (tec_to_busoff) begin
            state_d  = BUSOFF;
            tx_bit_d = 1'b1;
          end else begin
            state_d  = FLAG;
            // Flag polarity is fixed by the confinement state before this error is counted.
            tx_bit_d = (err_state != ST_ACTIVE);
          end
        end else if (bus.SP && bus.frame_ok) begin
          if (bus.tx_mode) begin
            if (tec_q != 9'd0) tec_d = tec_q - 9'd1;
          end else if (rec_q > 8'd127) begin
            rec_d = 8'd120;
          end else if (rec_q != 8'd0) begin
            rec_d = rec_q - 8'd1;
          end
        end
      end
      FLAG: begin
        if (bus.SP) begin
          if (cnt_q == FLAG_LAST) begin
            state_d  = DELIM_WAIT;
            cnt_d    = '0;
            tx_bit_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DELIM_WAIT: begin
        if (bus.SP && bus.rx_bit) begin
          if (DELIM_LEN <= 1) begin
            state_d = IDLE;
            cnt_d   = '0;
            error_d = 1'b1;
          end else begin
            state_d = DELIM;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      DELIM: begin
        if (bus.SP) begin
          if (!bus.rx_bit) begin
            state_d = DELIM_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == DELIM_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            error_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      BUSOFF: begin
        if (bus.SP) begin
          if (!bus.rx_bit) begin
            cnt_d = '0;
          end else if (cnt_q == RECOV_LAST) begin
            cnt_d = '0;
            if (seq_q == SEQ_LAST) begin
              state_d = IDLE;
              seq_d   = '0;
              tec_d   = '0;
              rec_d   = '0;
              error_d = 1'b1;
            end else begin
              seq_d = seq_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        seq_d    = '0;
        error_d  = 1'b1;
        tx_bit_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      seq_q    <= '0;
      tec_q    <= '0;
      rec_q    <= '0;
      error_q  <= 1'b1;
      tx_bit_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      seq_q    <= seq_d;
      tec_q    <= tec_d;
      rec_q    <= rec_d;
      error_q  <= error_d;
      tx_bit_q <= tx_bit_d;
    end
  end

  assign bus.ERROR     = error_q;
  assign bus.tx_bit    = tx_bit_q;
  assign bus.err_state = err_state;
  assign bus.TEC       = tec_q;
  assign bus.REC       = rec_q;
endmodule

// File: tb/tb_can_fault_confinement.sv
// Directed + randomized bench for can_fault_confinement; expected values come from an
// error-frame-level model of the counters and confinement rules held in plain integers.
module tb_can_fault_confinement;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   m_tec  = 0;
  int   m_rec  = 0;

  can_fault_confinement_if b ();

  can_fault_confinement dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic int m_state();
    if (m_tec >= 256) return 2;
    if (m_tec >= 128 || m_rec >= 128) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int err, input int txb);
    chk({tag, ".ERROR"},     32'(b.ERROR),     err);
    chk({tag, ".tx_bit"},    32'(b.tx_bit),    txb);
    chk({tag, ".err_state"}, 32'(b.err_state), m_state());
    chk({tag, ".TEC"},       32'(b.TEC),       m_tec);
    chk({tag, ".REC"},       32'(b.REC),       m_rec);
  endtask

  // Cycles without SP carry random garbage that must have no effect.
  task automatic noise();
    b.SP       = 1'b0;
    b.rx_bit   = 1'($urandom);
    {b.STF_E, b.EOF_E, b.FRM_E, b.CRC_E} = 4'($urandom);
    b.tx_mode  = 1'($urandom);
    b.frame_ok = 1'($urandom);
  endtask

  task automatic bit_sp(input logic rx, input logic [3:0] fl, input logic txm, input logic fok);
    @(negedge clk);
    b.SP       = 1'b1;
    b.rx_bit   = rx;
    {b.STF_E, b.EOF_E, b.FRM_E, b.CRC_E} = fl;
    b.tx_mode  = txm;
    b.frame_ok = fok;
    @(posedge clk);
    #1;
    noise();
    repeat ($urandom_range(0, 1)) begin
      @(posedge clk);
      #1;
      noise();
    end
  endtask

  task automatic rnd_sp(input logic rx);
    bit_sp(rx, 4'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // One complete error frame: error SP, flag, optional delimiter disturbances, full delimiter.
  task automatic error_frame(input logic txm, input logic [3:0] fl, input logic fok,
                             input int brk, output bit boff);
    int fb;
    fb = (m_state() == 0) ? 0 : 1;
    if (txm) m_tec = (m_tec + 8 > 256) ? 256 : m_tec + 8;
    else     m_rec = (m_rec + 1 > 255) ? 255 : m_rec + 1;
    boff = (m_tec >= 256);
    bit_sp(1'($urandom), fl, txm, fok);
    if (boff) begin
      chk_all("busoff_entry", 0, 1);
      return;
    end
    chk_all("flag_entry", 0, fb);
    for (int i = 1; i <= 6; i++) begin
      rnd_sp(1'($urandom));
      chk_all("flag", 0, (i == 6) ? 1 : fb);
    end
    repeat ($urandom_range(0, 2)) begin
      bit_sp(1'b0, 4'hF, txm, 1'b0);
      chk_all("delim_wait", 0, 1);
    end
    if (brk > 0) begin
      repeat (brk) begin
        bit_sp(1'b1, 4'hF, txm, 1'b0);
        chk_all("delim_pre_break", 0, 1);
      end
      bit_sp(1'b0, 4'hF, txm, 1'b0);
      chk_all("delim_break", 0, 1);
    end
    for (int i = 1; i <= 8; i++) begin
      bit_sp(1'b1, 4'hF, txm, 1'b0);
      chk_all((i == 8) ? "delim_done" : "delim", (i == 8) ? 1 : 0, 1);
    end
  endtask

  task automatic ok_frame(input logic txm);
    if (txm) begin
      if (m_tec > 0) m_tec--;
    end else if (m_rec > 127) begin
      m_rec = 120;
    end else if (m_rec > 0) begin
      m_rec--;
    end
    bit_sp(1'($urandom), 4'hF, txm, 1'b1);
    chk_all("frame_ok", 1, 1);
  endtask

  // dom_seq is 0-based; dom_bit is the 1-based position of the dominant bit in that sequence.
  task automatic recover(input int dom_seq, input int dom_bit);
    for (int s = 0; s < 128; s++) begin
      if (s == dom_seq) begin
        repeat (dom_bit - 1) rnd_sp(1'b1);
        rnd_sp(1'b0);
        chk_all("busoff_dominant", 0, 1);
      end
      for (int k = 0; k < 11; k++) begin
        rnd_sp(1'b1);
        if (s == 127 && k == 10) begin
          m_tec = 0;
          m_rec = 0;
          chk_all("recovered", 1, 1);
        end else if (k == 10 || s == 127) begin
          chk_all("busoff_hold", 0, 1);
        end
      end
    end
  endtask

  task automatic hard_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    m_tec = 0;
    m_rec = 0;
    chk_all("reset_async", 1, 1);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit boff;
    int r;
    reset      = 1'b0;
    b.SP       = 1'b0;
    b.rx_bit   = 1'b1;
    {b.STF_E, b.EOF_E, b.FRM_E, b.CRC_E} = 4'hF;
    b.tx_mode  = 1'b0;
    b.frame_ok = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 1, 1);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      bit_sp(1'($urandom), 4'hF, 1'($urandom), 1'b0);
      chk_all("idle", 1, 1);
    end
    ok_frame(1'b1);
    ok_frame(1'b0);

    error_frame(1'b0, 4'b0111, 1'b0, 0, boff);
    chk("rx_stuff_rec", 32'(b.REC), 1);

    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: error_frame(1'b0, 4'($urandom_range(0, 14)), 1'($urandom),
                       ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0, boff);
        1: error_frame(1'b1, 4'($urandom_range(0, 14)), 1'($urandom),
                       ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0, boff);
        2: ok_frame(1'($urandom));
        default: begin
          bit_sp(1'($urandom), 4'hF, 1'($urandom), 1'b0);
          chk_all("idle_mix", 1, 1);
        end
      endcase
      if (r < 2 && boff) recover($urandom_range(0, 127), $urandom_range(1, 11));
    end

    hard_reset();
    for (int i = 0; i < 16; i++) error_frame(1'b1, 4'b1110, 1'b0, 0, boff);
    chk("tec_128", 32'(b.TEC), 128);
    chk("passive_at_128", 32'(b.err_state), 1);
    error_frame(1'b1, 4'b1110, 1'b0, 0, boff);
    for (int i = 0; i < 14; i++) error_frame(1'b1, 4'($urandom_range(0, 14)), 1'b0, 0, boff);
    chk("tec_248", 32'(b.TEC), 248);
    error_frame(1'b1, 4'b1101, 1'b0, 0, boff);
    chk("busoff_flag", 32'(boff), 1);
    chk("tec_sat_256", 32'(b.TEC), 256);
    recover(2, 5);

    hard_reset();
    for (int i = 0; i < 130; i++)
      error_frame(1'b0, 4'($urandom_range(0, 14)), 1'($urandom),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : 0, boff);
    chk("rec_130", 32'(b.REC), 130);
    ok_frame(1'b0);
    chk("rec_drop_120", 32'(b.REC), 120);
    for (int i = 0; i < 10; i++) error_frame(1'b0, 4'b1110, 1'b0, 0, boff);
    error_frame(1'b0, 4'b1011, 1'b1, 0, boff);
    chk("rec_err_beats_ok", 32'(b.REC), 131);

    // Error, two flag bits, then reset lands while the third flag SP is presented.
    m_rec = m_rec + 1;
    bit_sp(1'b1, 4'b0111, 1'b0, 1'b0);
    chk_all("pre_reset_flag", 0, 1);
    rnd_sp(1'b1);
    rnd_sp(1'b1);
    @(negedge clk);
    b.SP = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    m_tec = 0;
    m_rec = 0;
    chk_all("reset_midflag", 1, 1);
    @(posedge clk);
    #1;
    chk_all("reset_midflag_hold", 1, 1);
    @(negedge clk);
    b.SP  = 1'b0;
    reset = 1'b1;

    error_frame(1'b0, 4'b1110, 1'b0, 3, boff);
    chk("delim_break_rec", 32'(b.REC), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
